// File: rtl/serial_in.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : serial_in                                            |
// | Description : 8N1 UART receiver with a first-word fall-through     |
// |               receive FIFO and sticky overrun / framing flags.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module serial_in #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_avail,
  output logic       overrun,
  output logic       frame_err
);

  localparam int          C_DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam int          C_PW       = FIFO_DEPTH_LOG2;
  localparam logic [15:0] C_BIT_CNT  = 16'(CLKS_PER_BIT);
  localparam logic [15:0] C_HALF_CNT = 16'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0]  r_prime;
  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        w_push, w_frame_set, w_expire, w_fall;

  logic [7:0]  r_mem [C_DEPTH];
  logic [C_PW:0] r_wptr, r_rptr;
  logic        w_empty, w_full, w_pop, w_wr, w_ovr_set;
  logic        r_overrun, r_frame_err;

  // Two-flop synchronizer plus a previous-sample flop for edge detection.
  // r_prime keeps r_rx_prev low until the synchronizer holds real line
  // samples, so a line already low out of reset never looks like a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b0;
      r_prime   <= 2'b00;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_prime   <= {r_prime[0], 1'b1};
      r_rx_prev <= r_prime[1] & r_rx_sync;
    end
  end

  assign w_fall   = r_rx_prev & ~r_rx_sync;
  assign w_expire = (r_cnt <= 16'd1);

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state decode; the timer counts down and acts when it reaches 1.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = (r_cnt != 16'd0) ? r_cnt - 16'd1 : 16'd0;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_push        = 1'b0;
    w_frame_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 16'd0;
        if (w_fall) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = C_HALF_CNT;
        end
      end
      ST_START: begin
        if (w_expire) begin
          if (!r_rx_sync) begin
            w_state_nxt   = ST_DATA;
            w_cnt_nxt     = C_BIT_CNT;
            w_bit_idx_nxt = 3'd0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 16'd0;
          end
        end
      end
      ST_DATA: begin
        if (w_expire) begin
          w_shift_nxt = {r_rx_sync, r_shift[7:1]};
          w_cnt_nxt   = C_BIT_CNT;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_expire) begin
          w_cnt_nxt = 16'd0;
          if (r_rx_sync) begin
            w_push      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_frame_set = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        w_cnt_nxt = 16'd0;
        if (r_rx_sync) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[C_PW] != r_rptr[C_PW]) &&
                     (r_wptr[C_PW-1:0] == r_rptr[C_PW-1:0]);
  assign w_pop     = rd_en & ~w_empty;
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;

  // FIFO storage; contents are only visible through the empty gate below.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[C_PW-1:0]] <= r_shift;
  end

  // FIFO pointers and sticky error flags; a new event beats clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_overrun   <= w_ovr_set   | (r_overrun   & ~clr_err);
      r_frame_err <= w_frame_set | (r_frame_err & ~clr_err);
    end
  end

  assign rd_data   = w_empty ? 8'h00 : r_mem[r_rptr[C_PW-1:0]];
  assign rx_avail  = ~w_empty;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire
